// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: frame/button/song inputs and mixer-facing outputs of the game-flow controller
interface game_state_ctrl_if #(parameter int CNT_W = 8);
  logic frame_start;
  logic btn_start;
  logic btn_pause;
  logic song_done;
  logic [3:0] game_state;
  logic playing;
  logic [CNT_W-1:0] remain;
  logic score_clear;
  modport master(output frame_start, btn_start, btn_pause, song_done, input game_state, playing, remain, score_clear);
  modport slave(input frame_start, btn_start, btn_pause, song_done, output game_state, playing, remain, score_clear);
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-synchronous title/countdown/play/pause/finish sequencer for the layer mixer.
// Optional macro PAUSE_TIMEOUT_EN: auto-return to title after PAUSE_TIMEOUT_FRAMES frames in pause.
module game_state_ctrl #(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CNT_W = 8,
  parameter int PAUSE_TIMEOUT_FRAMES = 1800
) (
  input logic clk,
  input logic rst,
  game_state_ctrl_if.slave io
);
  typedef enum logic [2:0] {TITLE, COUNT, PLAY, PAUSE, FINISH} state_t;
  state_t state, nxt;
  logic start_prev, pause_prev, req_start, req_pause, done_flag;
  logic start_edge, pause_edge, start_eff, pause_eff, done_eff, fs, timeout;
  logic [CNT_W-1:0] rmn;
  assign fs = io.frame_start;
  assign start_edge = io.btn_start & ~start_prev;
  assign pause_edge = io.btn_pause & ~pause_prev;
  assign start_eff = req_start | start_edge;
  assign pause_eff = req_pause | pause_edge;
  assign done_eff = done_flag | io.song_done;
`ifdef PAUSE_TIMEOUT_EN
  localparam int PT_W = $clog2(PAUSE_TIMEOUT_FRAMES + 1);
  logic [PT_W-1:0] pause_cnt;
  assign timeout = pause_cnt == PT_W'(PAUSE_TIMEOUT_FRAMES - 1);
  always_ff @(posedge clk) begin
    if (rst) pause_cnt <= '0;
    else if (nxt == PAUSE && state != PAUSE) pause_cnt <= '0;
    else if (state == PAUSE && fs) pause_cnt <= pause_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = PAUSE_TIMEOUT_FRAMES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    rmn = (state == COUNT) ? io.remain : '0;
    case (state)
      TITLE: if (fs && start_eff) begin
        nxt = COUNT;
        rmn = CNT_W'(COUNTDOWN_FRAMES - 1);
      end
      COUNT: if (fs) begin
        if (io.remain == '0) nxt = PLAY;
        else rmn = io.remain - 1'b1;
      end
      PLAY: if (fs) nxt = done_eff ? FINISH : pause_eff ? PAUSE : PLAY;
      PAUSE: if (fs) nxt = (pause_eff | start_eff) ? PLAY : timeout ? TITLE : PAUSE;
      FINISH: if (fs && start_eff) nxt = TITLE;
      default: nxt = TITLE;
    endcase
  end
  // history regs reset high so a button held through reset produces no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TITLE;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      req_start <= 1'b0;
      req_pause <= 1'b0;
      done_flag <= 1'b0;
      io.game_state <= 4'd0;
      io.playing <= 1'b0;
      io.remain <= '0;
      io.score_clear <= 1'b0;
    end else begin
      state <= nxt;
      start_prev <= io.btn_start;
      pause_prev <= io.btn_pause;
      req_start <= ~fs & start_eff;
      req_pause <= ~fs & pause_eff;
      done_flag <= (state == PLAY) && (nxt == PLAY) && done_eff;
      io.game_state <= (nxt == TITLE) ? 4'd0 : (nxt == PAUSE || nxt == FINISH) ? 4'd2 : 4'd1;
      io.playing <= nxt == PLAY;
      io.remain <= rmn;
      io.score_clear <= (state == TITLE) && (nxt == COUNT);
    end
  end
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed scoreboard bench for game_state_ctrl (COUNTDOWN_FRAMES=4, PAUSE_TIMEOUT_FRAMES=5)
module tb_game_state_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [13:0] sb[$];
  string tags[$];
  always #5 clk = ~clk;
  game_state_ctrl_if #(.CNT_W(8)) ifc();
  game_state_ctrl #(.COUNTDOWN_FRAMES(4), .CNT_W(8), .PAUSE_TIMEOUT_FRAMES(5)) dut (
    .clk(clk),
    .rst(rst),
    .io(ifc.slave)
  );
  task automatic step(input logic fs, bs, bp, sd, input logic [3:0] gs, input logic pl,
                      input logic [7:0] rm, input logic sc, input string tag);
    logic [13:0] got, want;
    string t;
    ifc.frame_start = fs;
    ifc.btn_start = bs;
    ifc.btn_pause = bp;
    ifc.song_done = sd;
    sb.push_back({gs, pl, rm, sc});
    tags.push_back(tag);
    @(negedge clk);
    want = sb.pop_front();
    t = tags.pop_front();
    got = {ifc.game_state, ifc.playing, ifc.remain, ifc.score_clear};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got gs=%0d pl=%0d rm=%0d sc=%0d, want gs=%0d pl=%0d rm=%0d sc=%0d",
             t, got[13:10], got[9], got[8:1], got[0], want[13:10], want[9], want[8:1], want[0]);
    end
  endtask
  initial begin
    ifc.frame_start = 1'b0;
    ifc.btn_start = 1'b1;
    ifc.btn_pause = 1'b0;
    ifc.song_done = 1'b0;
    @(negedge clk);
    step(0, 1, 0, 0, 0, 0, 0, 0, "rst_a");
    step(1, 1, 0, 0, 0, 0, 0, 0, "rst_fs");
    rst = 1'b0;
    step(1, 1, 0, 0, 0, 0, 0, 0, "held_start_no_edge");
    step(0, 0, 0, 0, 0, 0, 0, 0, "release");
    step(1, 0, 0, 0, 0, 0, 0, 0, "title_fs1");
    step(1, 0, 0, 0, 0, 0, 0, 0, "title_fs2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "start_edge_midframe");
    step(1, 1, 0, 0, 1, 0, 3, 1, "enter_count");
    step(0, 0, 0, 0, 1, 0, 3, 0, "score_clear_width1");
    step(1, 0, 0, 0, 1, 0, 2, 0, "count_2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "count_1");
    step(1, 0, 0, 0, 1, 0, 0, 0, "count_0");
    step(1, 0, 0, 0, 1, 1, 0, 0, "enter_play");
    step(0, 0, 1, 0, 1, 1, 0, 0, "pause_edge_midframe");
    step(0, 0, 0, 0, 1, 1, 0, 0, "pause_wait_frame");
    step(1, 0, 0, 0, 2, 0, 0, 0, "enter_pause");
    step(0, 1, 0, 0, 2, 0, 0, 0, "start_in_pause");
    step(1, 0, 0, 0, 1, 1, 0, 0, "resume_by_start");
    step(0, 0, 1, 1, 1, 1, 0, 0, "done_and_pause");
    step(1, 0, 0, 0, 2, 0, 0, 0, "finish_priority");
    step(0, 1, 0, 0, 2, 0, 0, 0, "start_in_finish");
    step(1, 1, 0, 0, 0, 0, 0, 0, "finish_to_title");
    step(0, 0, 0, 0, 0, 0, 0, 0, "title_idle");
    step(1, 1, 0, 0, 1, 0, 3, 1, "start_coincident_fs");
    step(1, 0, 0, 0, 1, 0, 2, 0, "count_before_rst");
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst_beats_fs");
    rst = 1'b0;
    step(0, 0, 1, 0, 0, 0, 0, 0, "pause_in_title");
    step(1, 0, 0, 0, 0, 0, 0, 0, "pause_ignored_title");
    step(0, 0, 0, 1, 0, 0, 0, 0, "done_in_title");
    step(0, 1, 0, 0, 0, 0, 0, 0, "start_edge_2");
    step(1, 0, 0, 0, 1, 0, 3, 1, "enter_count_2");
    step(1, 0, 1, 0, 1, 0, 2, 0, "pause_ignored_count");
    step(1, 1, 0, 0, 1, 0, 1, 0, "start_ignored_count");
    step(1, 0, 0, 0, 1, 0, 0, 0, "count_0_b");
    step(1, 0, 0, 0, 1, 1, 0, 0, "enter_play_2");
    step(1, 0, 0, 0, 1, 1, 0, 0, "stale_done_ignored");
    step(0, 1, 1, 0, 1, 1, 0, 0, "start_pause_same");
    step(1, 0, 0, 0, 2, 0, 0, 0, "both_pause_wins");
    step(0, 0, 1, 0, 2, 0, 0, 0, "pause_edge_in_pause");
    step(1, 0, 0, 0, 1, 1, 0, 0, "resume_by_pause");
    step(1, 0, 1, 0, 2, 0, 0, 0, "pause_coincident_fs");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_fs1");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_fs2");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_fs3");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_fs4");
`ifdef PAUSE_TIMEOUT_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, "pause_timeout");
    step(0, 1, 0, 0, 0, 0, 0, 0, "start_edge_3");
    step(1, 0, 0, 0, 1, 0, 3, 1, "enter_count_3");
    step(1, 0, 0, 0, 1, 0, 2, 0, "count_2_c");
    step(1, 0, 0, 0, 1, 0, 1, 0, "count_1_c");
    step(1, 0, 0, 0, 1, 0, 0, 0, "count_0_c");
    step(1, 0, 0, 0, 1, 1, 0, 0, "enter_play_3");
    step(1, 0, 1, 0, 2, 0, 0, 0, "enter_pause_3");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pt_fs1");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pt_fs2");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pt_fs3");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pt_fs4");
    step(1, 0, 1, 0, 1, 1, 0, 0, "resume_beats_timeout");
`else
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_holds");
    step(1, 0, 0, 0, 2, 0, 0, 0, "pause_holds_2");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
